// File: rtl/seq_stream_pkg.sv
// Shared types and constants for the serial sequence stream blocks.
package seq_stream_pkg;

  localparam int unsigned SEQ_WIDTH = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/sequence_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer. Emits a
// registered bit stream with bit_valid/word_start qualifiers and holds
// the current bit while enable is low.
module sequence_serializer
  import seq_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = SEQ_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             enable,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             idle
);

  localparam int unsigned    IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [IW-1:0]    r_idx;
  logic             r_seq_out;
  logic             r_bit_valid;
  logic             r_word_start;

  logic             w_accept;
  logic             w_last;

  // Select the k-th emitted bit of a word according to the bit order.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [IW-1:0] k);
    logic [IW-1:0] pos;
    pos = MSB_FIRST ? (LAST - k) : k;
    return w[pos];
  endfunction

  // Handshake and finishing-bit decode from registered state.
  always_comb begin
    data_ready = ~r_hold_full;
    idle       = (r_state == IDLE) & ~r_hold_full;
    w_accept   = data_valid & ~r_hold_full;
    w_last     = (r_state == SHIFT) & enable & (r_idx == LAST);
  end

  // Serializer FSM: shift/hold storage and registered serial outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_idx        <= '0;
      r_seq_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_word_start <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift      <= data_in;
            r_idx        <= '0;
            r_seq_out    <= pick(data_in, '0);
            r_bit_valid  <= 1'b1;
            r_word_start <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (r_idx == LAST) begin
              // Next word comes from hold first; a same-cycle acceptance
              // can only happen when hold is empty.
              if (r_hold_full) begin
                r_shift      <= r_hold;
                r_hold_full  <= 1'b0;
                r_idx        <= '0;
                r_seq_out    <= pick(r_hold, '0);
                r_word_start <= 1'b1;
              end else if (w_accept) begin
                r_shift      <= data_in;
                r_idx        <= '0;
                r_seq_out    <= pick(data_in, '0);
                r_word_start <= 1'b1;
              end else begin
                r_idx        <= '0;
                r_seq_out    <= 1'b0;
                r_bit_valid  <= 1'b0;
                r_word_start <= 1'b0;
                r_state      <= IDLE;
              end
            end else begin
              r_idx        <= r_idx + 1'b1;
              r_seq_out    <= pick(r_shift, r_idx + 1'b1);
              r_word_start <= 1'b0;
            end
          end
          if (w_accept && !w_last) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sequence_out = r_seq_out;
  assign bit_valid    = r_bit_valid;
  assign word_start   = r_word_start;

endmodule
